// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl: command-side initiator for a WIDTH-bit Load/Up/Down counter.
// On an accepted Start it loads Start_Val into the counter, sweeps up to High,
// then down to Low, and repeats the full 0..MAX..0 sweep until the requested
// number of sweeps has completed.
// Optional feature macro: SWEEP_TRACK_CHECK_EN. When defined, an internal model of
// the counter is kept and any divergence aborts the sequence into a sticky error.
module updown_sweep_ctrl #(
    parameter int WIDTH = 5,
    parameter int SW_W  = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [WIDTH-1:0] Start_Val,
    input  logic [SW_W-1:0]  Sweeps,
    input  logic [WIDTH-1:0] Counter,
    input  logic             High,
    input  logic             Low,
    output logic [WIDTH-1:0] IN,
    output logic             Load,
    output logic             Up,
    output logic             Down,
    output logic             Busy,
    output logic             Done,
    output logic             Err,
    output logic [SW_W-1:0]  Sweep_Cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_UP,
        S_DOWN,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [WIDTH-1:0]  start_val_reg;
    logic [SW_W-1:0]   sweeps_reg;
    logic [SW_W-1:0]   sweep_cnt_reg;
    logic              start_ok;
    logic [SW_W:0]     cnt_inc;
    logic              last_sweep;
    logic              track_err;

    // Start is only honoured when no sequence is running (IDLE, or parked in ERR).
    assign start_ok   = Start && ((state_reg == S_IDLE) || (state_reg == S_ERR));
    // One extra bit so the completed-sweep count can never wrap before the compare.
    assign cnt_inc    = {1'b0, sweep_cnt_reg} + (SW_W+1)'(1);
    assign last_sweep = (cnt_inc >= {1'b0, sweeps_reg});

`ifdef SWEEP_TRACK_CHECK_EN
    logic [WIDTH-1:0] model_reg;
    logic             err_reg;

    // Counter is only trustworthy once the load has landed, i.e. from SETTLE on.
    assign track_err = ((state_reg == S_SETTLE) || (state_reg == S_UP) ||
                        (state_reg == S_DOWN)   || (state_reg == S_DONE)) &&
                       (Counter != model_reg);

    // Shadow copy of the counter, advanced by exactly the command we issue.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            model_reg <= '0;
        end else if (Load) begin
            model_reg <= start_val_reg;
        end else if (Up) begin
            model_reg <= model_reg + WIDTH'(1);
        end else if (Down) begin
            model_reg <= model_reg - WIDTH'(1);
        end
    end

    // Sticky error flag: set on divergence, cleared only by a new accepted Start.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_reg <= 1'b0;
        end else if (start_ok) begin
            err_reg <= 1'b0;
        end else if (track_err) begin
            err_reg <= 1'b1;
        end
    end

    assign Err = err_reg;
`else
    logic unused_counter;

    // Without tracking, only High/Low steer the sweep; Counter is not consulted.
    assign unused_counter = ^Counter;
    assign track_err      = 1'b0;
    assign Err            = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Captured sequence parameters and completed-sweep count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            start_val_reg <= '0;
            sweeps_reg    <= '0;
            sweep_cnt_reg <= '0;
        end else if (start_ok) begin
            start_val_reg <= Start_Val;
            sweeps_reg    <= (Sweeps == '0) ? SW_W'(1) : Sweeps;
            sweep_cnt_reg <= '0;
        end else if ((state_reg == S_DOWN) && Low && !track_err) begin
            sweep_cnt_reg <= cnt_inc[SW_W-1:0];
        end
    end

    // Next state and commands; commands gate on High/Low so the counter never overshoots.
    always_comb begin
        state_next = state_reg;
        Load       = 1'b0;
        Up         = 1'b0;
        Down       = 1'b0;
        Done       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (Start) state_next = S_LOAD;
            end
            S_LOAD: begin
                Load       = 1'b1;
                state_next = S_SETTLE;
            end
            S_SETTLE: begin
                state_next = track_err ? S_ERR : S_UP;
            end
            S_UP: begin
                Up = !High;
                if (track_err)  state_next = S_ERR;
                else if (High)  state_next = S_DOWN;
            end
            S_DOWN: begin
                Down = !Low;
                if (track_err)  state_next = S_ERR;
                else if (Low)   state_next = last_sweep ? S_DONE : S_UP;
            end
            S_DONE: begin
                Done       = !track_err;
                state_next = track_err ? S_ERR : S_IDLE;
            end
            S_ERR: begin
                if (Start) state_next = S_LOAD;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign IN        = start_val_reg;
    assign Busy      = (state_reg != S_IDLE) && (state_reg != S_ERR);
    assign Sweep_Cnt = sweep_cnt_reg;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl driving a behavioural 5-bit Load/Up/Down counter.
// Stimulus pushes the expected outcome of each sequence into a scoreboard queue;
// a monitor counts commands and pops/compares whenever Done pulses.
module tb_updown_sweep_ctrl;

    localparam int WIDTH = 5;
    localparam int SW_W  = 4;
    localparam int MAX   = 31;

    typedef struct {
        int unsigned sweep_cnt;
        int unsigned in_val;
        int unsigned ups;
        int unsigned downs;
        int          latency;   // cycles from Load to Done; -1 = not checked
    } exp_t;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             Start = 1'b0;
    logic [WIDTH-1:0] Start_Val = '0;
    logic [SW_W-1:0]  Sweeps = '0;
    logic [WIDTH-1:0] Counter;
    logic             High;
    logic             Low;
    logic [WIDTH-1:0] IN;
    logic             Load;
    logic             Up;
    logic             Down;
    logic             Busy;
    logic             Done;
    logic             Err;
    logic [SW_W-1:0]  Sweep_Cnt;

    logic [WIDTH-1:0] cnt;
    logic             force_en = 1'b0;
    logic [WIDTH-1:0] force_val = '0;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   done_count = 0;
    int   up_n = 0;
    int   down_n = 0;
    int   since_load = 0;

    updown_sweep_ctrl #(.WIDTH(WIDTH), .SW_W(SW_W)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Start_Val(Start_Val), .Sweeps(Sweeps),
        .Counter(Counter), .High(High), .Low(Low), .IN(IN), .Load(Load), .Up(Up),
        .Down(Down), .Busy(Busy), .Done(Done), .Err(Err), .Sweep_Cnt(Sweep_Cnt)
    );

    always #5 CLK = ~CLK;

    // The counter being commanded; the override lets a divergence be injected.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)       cnt <= '0;
        else if (Load) cnt <= IN;
        else if (Up)   cnt <= cnt + 5'd1;
        else if (Down) cnt <= cnt - 5'd1;
    end
    assign Counter = force_en ? force_val : cnt;
    assign High    = (Counter == 5'(MAX));
    assign Low     = (Counter == 5'd0);

    function automatic void check(input string name, input int unsigned act, input int unsigned req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    // Monitor: command bookkeeping each cycle, scoreboard compare on Done.
    always @(negedge CLK) begin
        if (RST) begin
            up_n = 0;
            down_n = 0;
            since_load = 0;
        end else begin
            check("cmd_onehot", ((int'(Load) + int'(Up) + int'(Down)) <= 1) ? 1 : 0, 1);
            if (Load) begin
                up_n = 0;
                down_n = 0;
                since_load = 0;
            end else begin
                since_load++;
            end
            if (Up) up_n++;
            if (Down) down_n++;
            if (Done) begin
                done_count++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got Done=1, expected no Done");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_sweep_cnt", Sweep_Cnt, e.sweep_cnt);
                    check("done_in", IN, e.in_val);
                    check("done_up_cycles", up_n, e.ups);
                    check("done_down_cycles", down_n, e.downs);
                    check("done_err", Err, 0);
                    if (e.latency >= 0) check("done_latency", since_load, e.latency);
                    $display("txn done: sweep_cnt=%0d in=%0d ups=%0d downs=%0d latency=%0d",
                             Sweep_Cnt, IN, up_n, down_n, since_load);
                end
            end
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    // Called at a negedge; Start is seen by exactly one rising edge.
    task automatic start_seq(input int sv, input int n);
        Start_Val = WIDTH'(sv);
        Sweeps    = SW_W'(n);
        Start     = 1'b1;
        @(negedge CLK);
        Start     = 1'b0;
        $display("txn start: start_val=%0d sweeps=%0d busy=%0d", sv, n, Busy);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k;
        k = 0;
        while (Busy && k < budget) begin
            @(negedge CLK);
            k++;
        end
        check(name, Busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k;
        int dc;
        // 1. Reset
        repeat (2) tick();
        RST = 1'b0;
        tick();
        check("rst_in", IN, 0);
        check("rst_load", Load, 0);
        check("rst_up", Up, 0);
        check("rst_down", Down, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_err", Err, 0);
        check("rst_sweep_cnt", Sweep_Cnt, 0);

        // 2. S=15, N=1: Up 16, Down 31, Done 4+2*31-15 cycles after Load
        sb.push_back('{1, 15, 16, 31, 51});
        start_seq(15, 1);
        check("t2_load", Load, 1);
        check("t2_in", IN, 15);
        check("t2_busy", Busy, 1);
        wait_idle(200, "t2_idle_timeout");
        check("t2_sweep_cnt_hold", Sweep_Cnt, 1);
        check("t2_counter_low", Counter, 0);

        // 3. S=31, N=2: zero Up, Down 31, Up 31, Down 31
        sb.push_back('{2, 31, 31, 62, -1});
        start_seq(31, 2);
        wait_idle(300, "t3_idle_timeout");
        check("t3_sweep_cnt_hold", Sweep_Cnt, 2);

        // 4. Start while Busy is ignored
        dc = done_count;
        sb.push_back('{1, 15, 16, 31, 51});
        start_seq(15, 1);
        repeat (10) tick();
        start_seq(3, 5);
        check("t4_in_kept", IN, 15);
        check("t4_sweep_cnt_kept", Sweep_Cnt, 0);
        check("t4_still_busy", Busy, 1);
        wait_idle(200, "t4_idle_timeout");
        repeat (5) tick();
        check("t4_one_done", done_count - dc, 1);
        check("t4_sweep_cnt", Sweep_Cnt, 1);

        // 5. Async reset mid-DOWN at Counter=20
        dc = done_count;
        start_seq(5, 1);
        k = 0;
        while (!(Down && Counter == 5'd20) && k < 200) begin
            tick();
            k++;
        end
        check("t5_reach_down20", (Down && Counter == 5'd20) ? 1 : 0, 1);
        #2 RST = 1'b1;
        #1;
        check("t5_busy", Busy, 0);
        check("t5_down", Down, 0);
        check("t5_up", Up, 0);
        check("t5_load", Load, 0);
        check("t5_in", IN, 0);
        check("t5_sweep_cnt", Sweep_Cnt, 0);
        check("t5_done", Done, 0);
        tick();
        RST = 1'b0;
        repeat (40) tick();
        check("t5_idle", Busy, 0);
        check("t5_no_done", done_count - dc, 0);

`ifdef SWEEP_TRACK_CHECK_EN
        // 6. Counter diverges from the model during UP
        dc = done_count;
        start_seq(10, 1);
        k = 0;
        while (!(Up && cnt == 5'd18) && k < 100) begin
            tick();
            k++;
        end
        check("t6_reach_up18", (Up && cnt == 5'd18) ? 1 : 0, 1);
        force_val = 5'd7;
        force_en  = 1'b1;
        tick();
        force_en  = 1'b0;
        check("t6_err", Err, 1);
        check("t6_up", Up, 0);
        check("t6_down", Down, 0);
        check("t6_busy", Busy, 0);
        repeat (10) tick();
        check("t6_err_sticky", Err, 1);
        check("t6_no_done", done_count - dc, 0);
        sb.push_back('{1, 31, 0, 31, 35});
        start_seq(31, 1);
        check("t6_err_cleared", Err, 0);
        check("t6_reload", Load, 1);
        wait_idle(200, "t6_idle_timeout");
`endif

        repeat (3) tick();
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
